pwm_capture: RTL and testbench

//   Receive-side counterpart of the pwm generator: measures duty cycle of an incoming

---
 rtl/pwm_capture.sv | 182 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty count of a fixed-period PWM input, one sample per frame,
// plus static-level reports while unlocked. Define PWM_CAP_GLITCH_FILTER_EN for a 3-tap majority filter.
`timescale 1ns/1ps
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             locked,
    output logic             frame_err
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] POS_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] POS_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] POS_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   HI_ZERO  = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   HI_ONE   = {{WIDTH{1'b0}}, 1'b1};

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out_s;
    logic                   pwm_s;
    logic                   pwm_s_q;
    logic                   rise_s;
    logic                   started_q;
    logic [WIDTH-1:0]       pos_q;
    logic [WIDTH:0]         hi_q;
    logic [WIDTH:0]         hi_sum_s;
    logic [WIDTH-1:0]       sample_q;
    logic                   sample_valid_q;
    logic                   locked_q;
    logic                   frame_err_q;

    // A full-high frame counts 2**WIDTH cycles, which must still report as all-ones.
    function automatic logic [WIDTH-1:0] sat_count(input logic [WIDTH:0] cnt);
        logic [WIDTH-1:0] res;
        if (cnt[WIDTH]) begin
            res = POS_LAST;
        end else begin
            res = cnt[WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Input synchronizer for the asynchronous PWM line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign sync_out_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    // History of the two previous synchronized samples for the majority vote.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sync_out_s};
        end
    end

    assign pwm_s = maj3(sync_out_s, hist_q[0], hist_q[1]);
`else
    assign pwm_s = sync_out_s;
`endif

    // Previous filtered level, used for rising-edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_s_q <= 1'b0;
        end else begin
            pwm_s_q <= pwm_s;
        end
    end

    assign rise_s   = pwm_s & ~pwm_s_q;
    assign hi_sum_s = hi_q + {{WIDTH{1'b0}}, pwm_s};

    // Capture FSM: arming, frame measurement and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            pos_q          <= POS_ZERO;
            hi_q           <= HI_ZERO;
            started_q      <= 1'b0;
            sample_q       <= POS_ZERO;
            sample_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            if (!en) begin
                // Disabling wins over any frame-end or error event this cycle.
                state_q   <= IDLE;
                pos_q     <= POS_ZERO;
                hi_q      <= HI_ZERO;
                started_q <= 1'b0;
                locked_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= ARM;
                        pos_q     <= POS_ZERO;
                        hi_q      <= HI_ZERO;
                        started_q <= 1'b0;
                        locked_q  <= 1'b0;
                    end
                    ARM: begin
                        if (rise_s) begin
                            state_q   <= MEASURE;
                            pos_q     <= POS_ONE;
                            hi_q      <= HI_ONE;
                            started_q <= 1'b1;
                            locked_q  <= 1'b1;
                        end else begin
                            pos_q <= pos_q + POS_ONE;
                            if (pos_q == POS_LAST) begin
                                sample_q       <= pwm_s ? POS_LAST : POS_ZERO;
                                sample_valid_q <= 1'b1;
                            end
                        end
                    end
                    MEASURE: begin
                        if (rise_s && (pos_q != POS_ZERO)) begin
                            frame_err_q <= 1'b1;
                            pos_q       <= POS_ONE;
                            hi_q        <= HI_ONE;
                            started_q   <= 1'b1;
                        end else if (pos_q == POS_LAST) begin
                            sample_q       <= sat_count(hi_sum_s);
                            sample_valid_q <= 1'b1;
                            pos_q          <= POS_ZERO;
                            hi_q           <= HI_ZERO;
                            started_q      <= 1'b0;
                            if (!started_q) begin
                                state_q  <= ARM;
                                locked_q <= 1'b0;
                            end
                        end else begin
                            pos_q <= pos_q + POS_ONE;
                            hi_q  <= hi_sum_s;
                            if (rise_s) begin
                                started_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign locked       = locked_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: randomized PWM frames against a window-based reference model,
// with expected reports queued and checked by an independent output monitor.
`timescale 1ns/1ps
module tb_pwm_capture;
    localparam int WIDTH = 8;
    localparam int FRAME = 256;
    localparam int MAXE  = 40000;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             en;
    logic             pwm_i;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             locked;
    logic             frame_err;

    always #50 clk = ~clk;

    pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .pwm_i(pwm_i),
        .sample(sample), .sample_valid(sample_valid),
        .locked(locked), .frame_err(frame_err)
    );

    typedef struct {
        int ed;
        int val;
    } exp_t;

    exp_t sq[$];
    int   err_q[$];
    int   checks = 0;
    int   errors = 0;
    int   valids_seen = 0;
    bit   in_hist[MAXE];
    bit   ps_hist[MAXE];
    int   edge_n = 0;
    int   rst_edge = 0;
    // model modes: 0 idle, 1 waiting for a first rise, 2 measuring frames
    int   mode = 0;
    int   anchor = 0;
    int   fs = 0;
    bit   started = 1'b0;
    bit   exp_locked = 1'b0;
    int   last_sample = 0;
    exp_t mon_e;
    int   mon_err;

    function automatic void chk(string name, int got, int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, expv, edge_n);
        end
    endfunction

    function automatic int in_at(int k);
        if (k <= rst_edge) return 0;
        return int'(in_hist[k]);
    endfunction

    // Level seen by the capture logic at clock edge e.
    function automatic bit ps_at(int e);
`ifdef PWM_CAP_GLITCH_FILTER_EN
        int n;
        n = in_at(e - SYNC) + in_at(e - SYNC - 1) + in_at(e - SYNC - 2);
        return n >= 2;
`else
        return in_at(e - SYNC) != 0;
`endif
    endfunction

    task automatic model_step(input bit en_v);
        int e;
        int sum;
        bit ps;
        bit ps_prev;
        bit rise;
        e = edge_n;
        ps = ps_at(e);
        ps_hist[e] = ps;
        ps_prev = (e - 1 <= rst_edge) ? 1'b0 : ps_hist[e-1];
        rise = ps && !ps_prev;
        if (!en_v) begin
            mode = 0;
        end else if (mode == 0) begin
            mode = 1;
            anchor = e;
        end else if (mode == 1) begin
            if (rise) begin
                mode = 2;
                fs = e;
                started = 1'b1;
            end else if (e - anchor == FRAME) begin
                sq.push_back('{ed: e, val: (ps ? FRAME - 1 : 0)});
                anchor = e;
            end
        end else begin
            if (rise && e != fs) begin
                err_q.push_back(e);
                fs = e;
                started = 1'b1;
            end else begin
                if (rise) started = 1'b1;
                if (e - fs == FRAME - 1) begin
                    sum = 0;
                    for (int k = fs; k <= e; k++) sum += int'(ps_hist[k]);
                    sq.push_back('{ed: e, val: (sum > FRAME - 1) ? FRAME - 1 : sum});
                    if (!started) begin
                        mode = 1;
                        anchor = e;
                    end else begin
                        fs = e + 1;
                        started = 1'b0;
                    end
                end
            end
        end
        exp_locked = (mode == 2);
    endtask

    task automatic step(input bit en_v, input bit p);
        @(negedge clk);
        n_rst = 1'b1;
        en = en_v;
        pwm_i = p;
        edge_n++;
        if (edge_n >= MAXE) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", edge_n, MAXE);
            $fatal(1, "cycle budget exhausted");
        end
        in_hist[edge_n] = p;
        model_step(en_v);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        n_rst = 1'b0;
        en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            pwm_i = ~pwm_i;
        end
        rst_edge = edge_n;
        mode = 0;
        started = 1'b0;
        exp_locked = 1'b0;
        sq.delete();
        err_q.delete();
    endtask

    task automatic frame(input int duty, input int inj_pos, input int inj_w,
                         input int off_pos, input int off_len);
        bit lvl;
        bit e_v;
        for (int p = 0; p < FRAME; p++) begin
            lvl = (p < duty) || (p >= inj_pos && p < inj_pos + inj_w);
            e_v = !(p >= off_pos && p < off_pos + off_len);
            step(e_v, lvl);
        end
    endtask

    // Output monitor: compares every post-edge output against the queued expectations.
    always @(posedge clk) begin
        #1;
        if (!n_rst) begin
            chk("rst_sample", int'(sample), 0);
            chk("rst_valid", int'(sample_valid), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_frame_err", int'(frame_err), 0);
            last_sample = 0;
        end else begin
            chk("locked", int'(locked), int'(exp_locked));
            if (sample_valid) begin
                valids_seen++;
                if (sq.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    mon_e = sq.pop_front();
                    chk("valid_edge", edge_n, mon_e.ed);
                    chk("sample", int'(sample), mon_e.val);
                    last_sample = mon_e.val;
                end
            end else begin
                if (sq.size() > 0 && sq[0].ed <= edge_n) begin
                    chk("valid_missing", 0, 1);
                    void'(sq.pop_front());
                end
                chk("sample_hold", int'(sample), last_sample);
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    chk("frame_err_unexpected", 1, 0);
                end else begin
                    mon_err = err_q.pop_front();
                    chk("frame_err_edge", edge_n, mon_err);
                end
            end else if (err_q.size() > 0 && err_q[0] <= edge_n) begin
                chk("frame_err_missing", 0, 1);
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        int duty;
        int inj;
        int w;
        int off;
        n_rst = 1'b0;
        en = 1'b0;
        pwm_i = 1'b0;
        do_reset(8);
        repeat (4) frame(127, -1, 0, -1, 0);
        repeat (600) step(1'b1, 1'b0);
        repeat (900) step(1'b1, 1'b1);
        repeat (3) frame(255, -1, 0, -1, 0);
        repeat (3) frame(1, -1, 0, -1, 0);
        repeat (2) frame(64, -1, 0, -1, 0);
        frame(64, 100, 2, -1, 0);
        repeat (2) frame(64, -1, 0, -1, 0);
        frame(64, -1, 0, 50, 20);
        repeat (2) frame(64, -1, 0, -1, 0);
        frame(0, 120, 1, -1, 0);
        repeat (2) frame(200, -1, 0, -1, 0);
        for (int i = 0; i < 24; i++) begin
            duty = $urandom_range(0, FRAME - 1);
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FRAME - 1) : -1;
            w = $urandom_range(1, 3);
            off = ($urandom_range(0, 7) == 0) ? $urandom_range(0, FRAME - 1) : -1;
            if (i == 12) begin
                for (int p = 0; p < 100; p++) step(1'b1, p < duty);
                do_reset($urandom_range(1, 4));
            end else begin
                frame(duty, inj, w, off, $urandom_range(1, 40));
            end
        end
        repeat (3) step(1'b1, 1'b0);
        @(posedge clk);
        #5;
        chk("pending_samples", sq.size(), 0);
        chk("pending_frame_errs", err_q.size(), 0);
        chk("valids_seen_nonzero", int'(valids_seen > 20), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
